// File: rtl/seq_pkg.sv
// Shared definitions for the seqgen transmitter and the seqdec detector:
// FSM state encodings and the default sync pattern.
package seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int                  SYNC_LEN  = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_1101 = 4'b1101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seqgen_if.sv
// Frame request handshake and serial output bundle of seqgen.
interface seqgen_if #(
  parameter int DATA_W = 8
) ();

  // A frame is accepted on a rising clock edge where start && ready; payload is
  // captured on that same edge. start while ready=0 is dropped, never queued.
  logic              start;
  logic [DATA_W-1:0] payload;
  logic              ready;
  logic              data_out;
  logic              bit_valid;
  logic              frame_done;

  modport master (
    output start, payload,
    input  ready, data_out, bit_valid, frame_done
  );

  modport slave (
    input  start, payload,
    output ready, data_out, bit_valid, frame_done
  );

endinterface

// File: rtl/seqgen_piso.sv
// Parallel-in/serial-out payload register: MSB-first, left shift with zero fill.
module seqgen_piso #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seqgen.sv
// Serial frame transmitter: sync header then payload, MSB first, one bit per
// clock, followed by an optional forced idle gap.
module seqgen
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = SYNC_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SYNC_1101,
  parameter int                 DATA_W  = 8,
  parameter int                 GAP     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  seqgen_if.slave    bus,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(max3(PAT_LEN, DATA_W, GAP) + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] HEAD_LAST = CW'(PAT_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [PAT_LEN-1:0] hdr_sr;
  logic               dout_q;
  logic               valid_q;
  logic               done_q;
  logic               accept;
  logic               piso_shift;
  logic               piso_msb;

  assign accept     = (state == ST_IDLE) && bus.start;
  // The payload MSB goes out on the last header edge, so shifting starts there.
  assign piso_shift = ((state == ST_HEAD) && (cnt == '0)) ||
                      ((state == ST_DATA) && (cnt != '0));

  seqgen_piso #(.W(DATA_W)) u_piso (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .shift   (piso_shift),
    .din     (bus.payload),
    .msb     (piso_msb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hdr_sr  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_HEAD;
            cnt     <= HEAD_LAST;
            hdr_sr  <= PATTERN << 1;
            dout_q  <= PATTERN[PAT_LEN-1];
            valid_q <= 1'b1;
          end
        end
        ST_HEAD: begin
          if (cnt == '0) begin
            state  <= ST_DATA;
            cnt    <= DATA_LAST;
            dout_q <= piso_msb;
            done_q <= (DATA_W == 1);
          end else begin
            cnt    <= cnt - ONE;
            dout_q <= hdr_sr[PAT_LEN-1];
            hdr_sr <= hdr_sr << 1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            if (GAP > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_LAST;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt    <= cnt - ONE;
            dout_q <= piso_msb;
            done_q <= (cnt == ONE);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready      = (state == ST_IDLE);
  assign bus.data_out   = dout_q;
  assign bus.bit_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_seqgen.sv
// Bench for seqgen: reset, framing/timing, ignored start, back-to-back frames,
// mid-frame reset, and a 1101 detector loopback on a GAP=3 instance.
module tb_seqgen;
  import seq_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg3;

  int n_vec;
  int n_err;
  int vbits;

  logic [1:0] exp_q[$];

  seqgen_if #(.DATA_W(8)) bus  ();
  seqgen_if #(.DATA_W(8)) bus3 ();

  seqgen #(.DATA_W(8), .GAP(1)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  seqgen #(.DATA_W(8), .GAP(3)) u_dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus3),
    .state_dbg (state_dbg3)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] pl);
    logic [3:0] hdr;
    hdr = SYNC_1101;
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, hdr[i]});
    for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 0), pl[i]});
  endtask

  // scoreboard on the GAP=1 instance: every valid bit must match the queue head
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.bit_valid) begin
        vbits++;
        if (exp_q.size() == 0) begin
          check("sb_extra_bit", 1, 0);
        end else begin
          check("sb_bit", {bus.frame_done, bus.data_out}, exp_q.pop_front());
        end
      end else begin
        check("sb_idle", {bus.frame_done, bus.data_out}, 0);
      end
    end
  end

  // reference 1101 detector fed from the GAP=3 instance
  logic [3:0] det_hist;
  logic       det_hit;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      det_hist <= '0;
      det_hit  <= 1'b0;
    end else begin
      det_hist <= {det_hist[2:0], bus3.data_out};
      det_hit  <= ({det_hist[2:0], bus3.data_out} == 4'b1101);
    end
  end

  initial begin
    #100000;
    check("timeout", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [11:0] exp_stream;
    int          hits;
    int          bv3;

    n_vec = 0;
    n_err = 0;
    vbits = 0;

    // reset with start asserted: nothing may start
    reset_n      = 1'b0;
    bus.start    = 1'b1;
    bus.payload  = 8'hFF;
    bus3.start   = 1'b1;
    bus3.payload = 8'hFF;
    repeat (3) begin
      tick();
      check("rst_ready", bus.ready, 1);
      check("rst_valid", bus.bit_valid, 0);
      check("rst_dout", bus.data_out, 0);
      check("rst_done", bus.frame_done, 0);
    end
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    reset_n    = 1'b1;
    tick();
    tick();
    check("idle_ready", bus.ready, 1);
    check("idle_state", state_dbg, ST_IDLE);

    // basic frame A5, accept edge is cycle 0
    exp_stream  = 12'b1101_1010_0101;
    bus.payload = 8'hA5;
    bus.start   = 1'b1;
    push_frame(8'hA5);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      check("basic_dout", bus.data_out, (c <= 12) ? exp_stream[12-c] : 1'b0);
      check("basic_valid", bus.bit_valid, (c <= 12));
      check("basic_done", bus.frame_done, (c == 12));
      check("basic_ready", bus.ready, (c == 14));
      if (c < 14) tick();
    end
    tick();

    // start pulses while busy are ignored
    vbits       = 0;
    bus.payload = 8'h00;
    bus.start   = 1'b1;
    push_frame(8'h00);
    tick();
    for (int c = 1; c < 22; c++) begin
      bus.start   = (c == 3) || (c == 8);
      bus.payload = 8'hFF;
      tick();
    end
    bus.start = 1'b0;
    check("ign_bits", vbits, 12);
    check("ign_queue", exp_q.size(), 0);
    check("ign_ready", bus.ready, 1);

    // start held high: back-to-back frames at the frame period
    vbits       = 0;
    bus.payload = 8'h01;
    bus.start   = 1'b1;
    push_frame(8'h01);
    push_frame(8'h80);
    tick();
    bus.payload = 8'h80;
    for (int c = 1; c <= 15; c++) begin
      if (c == 1)  check("b2b_valid1", bus.bit_valid, 1);
      if (c == 14) begin
        check("b2b_ready14", bus.ready, 1);
        check("b2b_valid14", bus.bit_valid, 0);
      end
      if (c == 15) begin
        check("b2b_valid15", bus.bit_valid, 1);
        check("b2b_dout15", bus.data_out, 1);
        check("b2b_ready15", bus.ready, 0);
        bus.start = 1'b0;
      end
      if (c < 15) tick();
    end
    repeat (16) tick();
    check("b2b_bits", vbits, 24);
    check("b2b_queue", exp_q.size(), 0);

    // reset dropped in cycle 6 of a frame
    bus.payload = 8'hA5;
    bus.start   = 1'b1;
    push_frame(8'hA5);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("mrst_dout", bus.data_out, 0);
    check("mrst_valid", bus.bit_valid, 0);
    check("mrst_done", bus.frame_done, 0);
    check("mrst_ready", bus.ready, 1);
    check("mrst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    vbits   = 0;
    tick();
    bus.payload = 8'h3C;
    bus.start   = 1'b1;
    push_frame(8'h3C);
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    check("mrst_bits", vbits, 12);
    check("mrst_queue", exp_q.size(), 0);

    // loopback into the 1101 detector, GAP=3, three frames of 00
    hits         = 0;
    bv3          = 0;
    bus3.payload = 8'h00;
    bus3.start   = 1'b1;
    tick();
    for (int c = 1; c <= 50; c++) begin
      check("loop_hit", det_hit, (c == 5) || (c == 21) || (c == 37));
      if (det_hit) hits++;
      if (bus3.bit_valid) bv3++;
      if (c == 33) bus3.start = 1'b0;
      tick();
    end
    check("loop_hits", hits, 3);
    check("loop_bits", bv3, 36);
    check("loop_ready", bus3.ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seqgen.md
# seqgen

Serial pattern-framed transmitter that generates the bit stream recognised by the team's `seqdec` 1101 detector. It accepts a parallel payload word through a start/ready handshake and emits a sync header (`PATTERN`, MSB first) followed by the payload (MSB first) on a single serial line, one bit per clock. An optional idle gap follows each frame. It sits at the source end of the serial test/link path, upstream of `seqdec`.

## Interface
- `PATTERN`, 4'b1101: sync header bits, sent MSB first.
- `PAT_LEN`, 4: number of header bits, range 1..16.
- `DATA_W`, 8: payload width, range 1..32.
- `GAP`, 1: forced idle cycles after each frame, range 0..15.

- `clock`, in, 1: single clock; all logic is posedge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: frame request; sampled only while `ready`=1.
- `payload`, in, DATA_W: frame data; captured on the accepting edge.
- `ready`, out, 1: high only in IDLE; block can accept `start`.
- `data_out`, out, 1: serial bit; 0 whenever `bit_valid`=0.
- `bit_valid`, out, 1: high while a header or payload bit is driven.
- `frame_done`, out, 1: one-cycle pulse while the last payload bit is on `data_out`.

## Operation
- FSM states and transitions:
  - IDLE to HEAD on `start`=1.
  - HEAD to DATA after `PAT_LEN` bits.
  - DATA to GAP after `DATA_W` bits when `GAP`>0, otherwise DATA to IDLE.
  - GAP to IDLE after `GAP` cycles.
- Handshake: accept when `start`=1 and `ready`=1 on a rising edge. `payload` is latched into a DATA_W shift register. `start` while busy is ignored, not queued.
- HEAD: `data_out` = `PATTERN[PAT_LEN-1-i]` for i = 0..PAT_LEN-1.
- DATA: `data_out` = shift-register MSB. Shift left by 1 per cycle, zero fill.
- GAP and IDLE: `data_out`=0 and `bit_valid`=0, so no stray 1s reach the detector.
- Down-counter width is `$clog2(max(PAT_LEN,DATA_W,GAP)+1)`. It loads N-1 on state entry and leaves the state at 0. No wrap-around is possible.
- `data_out`, `bit_valid` and `frame_done` are registered outputs. `ready` is decoded from state.
- Reset, including mid-frame: asynchronous return to IDLE, shift register and counter cleared, and the partial frame is discarded.
- Reset values: `data_out`=0, `bit_valid`=0, `frame_done`=0, `ready`=1 (state IDLE). `start` is ignored while `reset_n`=0.

## Timing
- The accept edge is cycle 0.
- The first header bit is on `data_out` in cycle 1, so latency is 1 clock.
- Header occupies cycles 1..PAT_LEN.
- Payload occupies cycles PAT_LEN+1..PAT_LEN+DATA_W. `frame_done`=1 in the last of these cycles.
- GAP occupies the following `GAP` cycles. `ready` rises in the next cycle after that.
- Frame period is PAT_LEN+DATA_W+GAP+1 cycles. There is at least one IDLE cycle between frames, even with GAP=0.
- `bit_valid` is high for exactly PAT_LEN+DATA_W consecutive cycles per frame.
- `start` held high continuously produces back-to-back frames at the frame period. Each frame captures the `payload` present on its own accept edge.

## Structure
- Shared package `seq_pkg` contains:
  - the state encoding localparams (IDLE, HEAD, DATA, GAP);
  - the default sync pattern `SYNC_1101` and its length, shared with `seqdec`.
- One natural sub-module is `seqgen_piso`, the DATA_W parallel-in/serial-out shift register with `load` and `shift` enables. The FSM, counter and output registers stay in `seqgen`.

## Test plan
- Reset behaviour: assert `reset_n`=0 with `start`=1. Then `ready`=1, `data_out`=0, `bit_valid`=0, `frame_done`=0, and no frame starts until release.
- Basic frame, defaults, `payload`=8'hA5 accepted at cycle 0:
  - `data_out` = 1,1,0,1 in cycles 1..4;
  - `data_out` = 1,0,1,0,0,1,0,1 in cycles 5..12;
  - `frame_done` only in cycle 12, gap in cycle 13, `ready` high in cycle 14.
- Ignored start: pulse `start` with `payload`=8'hFF at cycles 3 and 8 of a frame carrying 8'h00. The output is unchanged and exactly one frame is sent.
- Back-to-back frames: `start` held high with `payload` stepping 8'h01 then 8'h80. Frames begin at cycles 1 and 15, and each carries the value present on its accept edge.
- Reset mid-frame: drop `reset_n` at cycle 6. Outputs go to 0 immediately, and after release the next `start` produces a full, clean frame.
- Loopback: feed `data_out` into `seqdec` with `payload`=8'h00 and GAP=3. The detector flags exactly once per frame, one cycle after the 4th header bit.
